// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_e  : responder FSM states
//   req_t    : latched request (we, addr, wdata, be)
//   addr_err : misalignment / range check for a byte address
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    // A request is in error when it is not word aligned or its word index
    // falls beyond the last stored word.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth);
        logic [WORD_W-1:0] idx;
        idx = {2'b00, addr[WORD_W-1:2]};
        return (addr[1:0] != 2'b00) || (idx >= $unsigned(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage with one byte-enabled synchronous write port
// and one combinational read port sharing the same word index.
//   clk   : clock, rising edge
//   we    : write strobe (qualified by be per byte)
//   idx   : word index
//   wdata : write data
//   be    : byte enables, bit i selects wdata[8i+7:8i]
//   rdata : word currently stored at idx
// Contents are deliberately not reset.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Byte-lane writes; lanes with be cleared keep their old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we && be[i]) begin
                mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder. Accepts one request at a time on a
// valid/ready handshake and returns exactly one response LATENCY cycles
// after acceptance.
//   clk, reset            : clock (rising edge), async active-high reset
//   req_valid / req_ready : request handshake
//   req_we, req_addr      : 1 = store / 0 = load, byte address
//   req_wdata, req_be     : store data and byte enables
//   resp_valid            : one-cycle response pulse
//   resp_rdata, resp_err  : load data (0 for stores/errors), error flag
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    req_t              req_r, req_s;
    logic              req_ready_r, req_ready_s;
    logic              resp_valid_r, resp_valid_s;
    logic [WORD_W-1:0] resp_rdata_r, resp_rdata_s;
    logic              resp_err_r, resp_err_s;
    logic              wr_en_s;
    logic              bad_s;
    logic [WORD_W-1:0] rd_word_s;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (wr_en_s),
        .idx   (req_r.addr[AW+1:2]),
        .wdata (req_r.wdata),
        .be    (req_r.be),
        .rdata (rd_word_s)
    );

    // State, counter, latched request and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            req_r        <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            req_r        <= req_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            resp_rdata_r <= resp_rdata_s;
            resp_err_r   <= resp_err_s;
        end
    end

    // Next-state, counter, access strobe and next response values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        req_s        = req_r;
        resp_valid_s = 1'b0;
        resp_rdata_s = resp_rdata_r;
        resp_err_s   = resp_err_r;
        wr_en_s      = 1'b0;
        bad_s        = addr_err(req_r.addr, DEPTH);

        case (state_r)
            IDLE, RESP: begin
                if (req_valid) begin
                    req_s   = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                    cnt_s   = CNT_LOAD;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r != CNT_W'(0)) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    // Access edge: write, read and error decision all happen here.
                    wr_en_s      = req_r.we && !bad_s;
                    resp_valid_s = 1'b1;
                    resp_err_s   = bad_s;
                    if (bad_s || req_r.we) begin
                        resp_rdata_s = 32'd0;
                    end else begin
                        resp_rdata_s = rd_word_s;
                    end
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Ready is registered, so it is derived from where the FSM is heading.
        req_ready_s = (state_s != BUSY);
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2 instance (a_*) and LATENCY=1 instance (b_*)
    logic        rst0, rst1;
    logic        a_valid, a_ready, a_we, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_valid, b_ready, b_we, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst0), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the LATENCY=2 instance
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            exp_t e;
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lat2_unexpected_resp: got response at cycle %0d want none", cyc);
            end else begin
                e = q0.pop_front();
                check("lat2_rdata", a_rdata, e.rdata);
                check("lat2_err", {31'd0, a_err}, {31'd0, e.err});
                check("lat2_resp_cycle", cyc, e.at);
            end
        end
    end

    // Monitor for the LATENCY=1 instance
    always @(negedge clk) begin
        if (b_rvalid === 1'b1) begin
            exp_t e;
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lat1_unexpected_resp: got response at cycle %0d want none", cyc);
            end else begin
                e = q1.pop_front();
                check("lat1_rdata", b_rdata, e.rdata);
                check("lat1_err", {31'd0, b_err}, {31'd0, e.err});
                check("lat1_resp_cycle", cyc, e.at);
            end
        end
    end

    // Present a request to dut0 and hold it until accepted; acc is the edge number.
    task automatic send0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                         input bit track, output int acc);
        int n = 0;
        exp_t e;
        @(negedge clk);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
        while (a_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL lat2_ready_timeout: got no req_ready within %0d cycles want ready", n);
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (track) begin
                e.rdata = exp_rd; e.err = exp_err; e.at = acc + 2;
                q0.push_back(e);
            end
            @(negedge clk);
            check("lat2_busy_ready", {31'd0, a_ready}, 32'd0);
        end
    endtask

    task automatic send1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                         output int acc);
        int n = 0;
        exp_t e;
        @(negedge clk);
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
        while (b_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL lat1_ready_timeout: got no req_ready within %0d cycles want ready", n);
            acc = -1;
        end else begin
            acc = cyc + 1;
            e.rdata = exp_rd; e.err = exp_err; e.at = acc + 1;
            q1.push_back(e);
            @(negedge clk);
            check("lat1_busy_ready", {31'd0, b_ready}, 32'd0);
        end
    endtask

    // Drop valid, scramble request inputs (must be ignored) and wait for responses.
    task automatic drain0();
        int n = 0;
        a_valid = 1'b0; a_we = ~a_we; a_addr = 32'h0000_0010; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
        while (q0.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL lat2_drain_timeout: got %0d pending responses want 0", q0.size());
            q0.delete();
        end
        @(negedge clk);
    endtask

    task automatic drain1();
        int n = 0;
        b_valid = 1'b0;
        while (q1.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL lat1_drain_timeout: got %0d pending responses want 0", q1.size());
            q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc [4];
        int t;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_be = 4'h0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_be = 4'h0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, a_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, a_rvalid}, 32'd0);
        check("rst_resp_rdata", a_rdata, 32'd0);
        check("rst_resp_err", {31'd0, a_err}, 32'd0);
        check("rst1_req_ready", {31'd0, b_ready}, 32'd1);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // store-then-load
        send0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 1'b1, t);
        drain0();
        send0(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, t);
        drain0();

        // byte enables, including an all-zero byte-enable store
        send0(1'b1, 32'h20, 32'h11223344, 4'hF, 32'd0, 1'b0, 1'b1, t);
        drain0();
        send0(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0, 1'b1, t);
        drain0();
        send0(1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, t);
        drain0();
        send0(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, 1'b1, t);
        drain0();
        send0(1'b0, 32'h20, 32'd0, 4'hF, 32'h11BB33DD, 1'b0, 1'b1, t);
        drain0();

        // errors: misaligned load, out-of-range store that aliases index 0
        send0(1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, 1'b1, t);
        drain0();
        send0(1'b0, 32'h22, 32'd0, 4'hF, 32'd0, 1'b1, 1'b1, t);
        drain0();
        send0(1'b1, 32'h100, 32'h99999999, 4'hF, 32'd0, 1'b1, 1'b1, t);
        drain0();
        send0(1'b0, 32'h00, 32'd0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, t);
        drain0();

        // last word in range
        send0(1'b1, 32'hFC, 32'h0BADCAFE, 4'hF, 32'd0, 1'b0, 1'b1, t);
        drain0();
        send0(1'b0, 32'hFC, 32'd0, 4'hF, 32'h0BADCAFE, 1'b0, 1'b1, t);
        drain0();

        send0(1'b1, 32'h04, 32'h12345678, 4'hF, 32'd0, 1'b0, 1'b1, t);
        drain0();

        // back-to-back loads with req_valid held high
        send0(1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, acc[0]);
        send0(1'b0, 32'h20, 32'd0, 4'hF, 32'h11BB33DD, 1'b0, 1'b1, acc[1]);
        send0(1'b0, 32'h00, 32'd0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, acc[2]);
        send0(1'b0, 32'h04, 32'd0, 4'hF, 32'h12345678, 1'b0, 1'b1, acc[3]);
        drain0();
        for (int i = 1; i < 4; i++) begin
            check("lat2_accept_spacing", acc[i] - acc[i-1], 32'd3);
        end

        // reset in the BUSY cycle just before the access edge
        send0(1'b1, 32'h04, 32'h00000055, 4'hF, 32'd0, 1'b0, 1'b0, t);
        a_valid = 1'b0;
        @(negedge clk);
        rst0 = 1'b1;
        #1;
        check("midrst_req_ready", {31'd0, a_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, a_rvalid}, 32'd0);
        check("midrst_resp_rdata", a_rdata, 32'd0);
        check("midrst_resp_err", {31'd0, a_err}, 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        send0(1'b0, 32'h04, 32'd0, 4'hF, 32'h12345678, 1'b0, 1'b1, t);
        drain0();

        // LATENCY=1 instance: store then back-to-back load
        send1(1'b1, 32'h08, 32'h01020304, 4'hF, 32'd0, 1'b0, acc[0]);
        send1(1'b0, 32'h08, 32'd0, 4'hF, 32'h01020304, 1'b0, acc[1]);
        send1(1'b0, 32'h06, 32'd0, 4'hF, 32'd0, 1'b1, acc[2]);
        drain1();
        check("lat1_accept_spacing", acc[1] - acc[0], 32'd2);
        check("lat1_accept_spacing", acc[2] - acc[1], 32'd2);

        check("lat2_pending_at_end", q0.size(), 32'd0);
        check("lat1_pending_at_end", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
